// File: rtl/multi_button_detector_if.sv
// multi_button_detector_if: button pins in, debounced level plus event/long-press pulses out.
interface multi_button_detector_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0] in;
    logic [N_CH-1:0] level;
    logic [N_CH-1:0] out;
    logic [N_CH-1:0] long_press;
    modport master (output in, input level, out, long_press);
    modport slave (input in, output level, out, long_press);
endinterface

// File: rtl/multi_button_detector.sv
// multi_button_detector: per-channel sync, counter debounce, edge events and long-press detection.
// Define MBD_AUTO_REPEAT_EN to add auto-repeat pulses on out while a long press is held.
module multi_button_detector #(
    parameter int N_CH          = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int DB_CYCLES     = 1000000,
    parameter int LONG_CYCLES   = 50000000,
    parameter int EDGE_MODE     = 0,
    parameter int ACTIVE_LOW_IN = 0,
    parameter int RPT_CYCLES    = 10000000
) (
    input logic clk,
    input logic rst,
    multi_button_detector_if.slave bus
);
    localparam int DW = $clog2(DB_CYCLES + 1);
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam int EM = (EDGE_MODE >= 0 && EDGE_MODE <= 2) ? EDGE_MODE : 0;
    localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

    if (N_CH < 1 || SYNC_STAGES < 2 || DB_CYCLES < 1 || LONG_CYCLES < 1 || RPT_CYCLES < 1) begin : g_param_check
        $error("multi_button_detector: parameter out of range");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync;
        logic [DW-1:0] db_cnt;
        logic [HW-1:0] hold;
        logic p, s, lvl, lvl_d, rise, fall, ev, rpt_pulse, o, lp;
        assign p = (ACTIVE_LOW_IN != 0) ? ~bus.in[i] : bus.in[i];
        assign s = sync[SYNC_STAGES-1];
        assign rise = lvl & ~lvl_d;
        assign fall = ~lvl & lvl_d;
        assign ev = (EM == 1) ? fall : (EM == 2) ? (rise | fall) : rise;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                sync   <= '0;
                db_cnt <= '0;
                lvl    <= 1'b0;
                lvl_d  <= 1'b0;
                hold   <= '0;
                lp     <= 1'b0;
                o      <= 1'b0;
            end else begin
                sync <= {sync[SYNC_STAGES-2:0], p};
                if (s == lvl) begin
                    db_cnt <= '0;
                end else if (db_cnt == DB_LAST) begin
                    lvl    <= s;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + DW'(1);
                end
                lvl_d <= lvl;
                hold  <= !lvl ? '0 : (hold == HOLD_MAX) ? hold : hold + HW'(1);
                // fires only on the step into saturation, so once per press
                lp    <= lvl && hold == HOLD_LAST;
                o     <= ev | rpt_pulse;
            end
        end

`ifdef MBD_AUTO_REPEAT_EN
        localparam int RW = $clog2(RPT_CYCLES + 1);
        localparam logic [RW-1:0] RPT_LAST = RW'(RPT_CYCLES - 1);
        logic [RW-1:0] rpt;
        logic armed;
        assign armed = lvl && hold == HOLD_MAX;
        assign rpt_pulse = (EM != 1) && armed && rpt == RPT_LAST;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) rpt <= '0;
            else rpt <= (!armed || rpt == RPT_LAST) ? '0 : rpt + RW'(1);
        end
`else
        assign rpt_pulse = 1'b0;
`endif

        assign bus.level[i] = lvl;
        assign bus.out[i] = o;
        assign bus.long_press[i] = lp;
    end
endmodule

// File: tb/tb_multi_button_detector.sv
// tb_multi_button_detector: directed vector table plus timed sequences for multi_button_detector.
module tb_multi_button_detector;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int n_chk = 0;
    int n_fail = 0;
    logic rpt_on;

    always #5 clk = ~clk;

    multi_button_detector_if #(.N_CH(4)) b0();
    multi_button_detector_if #(.N_CH(4)) b1();
    multi_button_detector_if #(.N_CH(4)) b2();
    assign b1.in = b0.in;

    multi_button_detector #(.N_CH(4), .SYNC_STAGES(2), .DB_CYCLES(4), .LONG_CYCLES(20),
        .EDGE_MODE(0), .ACTIVE_LOW_IN(0), .RPT_CYCLES(8)) u0 (.clk(clk), .rst(rst), .bus(b0));
    multi_button_detector #(.N_CH(4), .SYNC_STAGES(2), .DB_CYCLES(4), .LONG_CYCLES(20),
        .EDGE_MODE(2), .ACTIVE_LOW_IN(0), .RPT_CYCLES(8)) u1 (.clk(clk), .rst(rst), .bus(b1));
    multi_button_detector #(.N_CH(4), .SYNC_STAGES(2), .DB_CYCLES(4), .LONG_CYCLES(20),
        .EDGE_MODE(0), .ACTIVE_LOW_IN(1), .RPT_CYCLES(8)) u2 (.clk(clk), .rst(rst), .bus(b2));

    typedef struct {
        logic [3:0] in;
        int cyc;
        logic [3:0] lvl;
        logic [3:0] outs;
        logic [3:0] lps;
    } vec_t;
    vec_t vt[9];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // press mask m cleanly, check exact level/out timing, then release
    task automatic edge_seq(input logic [3:0] m);
        b0.in = m;
        for (int t = 1; t <= 10; t++) begin
            step();
            chk($sformatf("edge%0h lvl t%0d", m, t), b0.level, (t >= 6) ? m : 4'h0);
            chk($sformatf("edge%0h out t%0d", m, t), b0.out, (t == 7) ? m : 4'h0);
        end
        b0.in = 4'h0;
        idle(16);
    endtask

    initial begin
`ifdef MBD_AUTO_REPEAT_EN
        rpt_on = 1'b1;
`else
        rpt_on = 1'b0;
`endif
        vt = '{
            '{4'h0, 10, 4'h0, 4'h0, 4'h0},
            '{4'h2, 3, 4'h0, 4'h0, 4'h0},
            '{4'h0, 10, 4'h0, 4'h0, 4'h0},
            '{4'h2, 4, 4'h0, 4'h0, 4'h0},
            '{4'h0, 12, 4'h0, 4'h2, 4'h0},
            '{4'h9, 10, 4'h9, 4'h9, 4'h0},
            '{4'h0, 12, 4'h0, 4'h0, 4'h0},
            '{4'hF, 30, 4'hF, 4'hF, 4'hF},
            '{4'h0, 12, 4'h0, rpt_on ? 4'hF : 4'h0, 4'h0}
        };
        b0.in = 4'h0;
        b2.in = 4'hF;
        idle(3);
        chk("reset level", b0.level, 4'h0);
        chk("reset out", b0.out, 4'h0);
        chk("reset long_press", b0.long_press, 4'h0);
        rst = 1'b1;
        idle(5);

        edge_seq(4'h1);
        edge_seq(4'h9);

        for (int v = 0; v < 9; v++) begin
            int oc[4];
            int lc[4];
            logic [7:0] om;
            logic [3:0] lm;
            for (int c = 0; c < 4; c++) begin
                oc[c] = 0;
                lc[c] = 0;
            end
            b0.in = vt[v].in;
            repeat (vt[v].cyc) begin
                step();
                for (int c = 0; c < 4; c++) begin
                    oc[c] += int'(b0.out[c]);
                    lc[c] += int'(b0.long_press[c]);
                end
            end
            for (int c = 0; c < 4; c++) begin
                om[c] = (oc[c] == 1);
                om[c+4] = (oc[c] > 1);
                lm[c] = (lc[c] == 1) || (lc[c] > 1 && 1'bx);
            end
            chk($sformatf("vec%0d level", v), b0.level, vt[v].lvl);
            chk($sformatf("vec%0d out", v), om, {4'h0, vt[v].outs});
            chk($sformatf("vec%0d long", v), lm, vt[v].lps);
        end
        idle(10);

        b0.in = 4'h4;
        for (int t = 1; t <= 45; t++) begin
            step();
            chk($sformatf("long lp t%0d", t), b0.long_press, (t == 26) ? 4'h4 : 4'h0);
            chk($sformatf("long out t%0d", t), b0.out,
                (t == 7 || (rpt_on && (t == 34 || t == 42))) ? 4'h4 : 4'h0);
        end
        b0.in = 4'h0;
        idle(20);

        b0.in = 4'h8;
        idle(12);
        chk("pre-reset level", b0.level, 4'h8);
        b0.in = 4'h9;
        idle(5);
        #2;
        rst = 1'b0;
        #1;
        chk("async reset level", b0.level, 4'h0);
        chk("async reset out", b0.out, 4'h0);
        chk("async reset long", b0.long_press, 4'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int t = 1; t <= 9; t++) begin
            step();
            chk($sformatf("rst-rel lvl t%0d", t), b0.level, (t >= 6) ? 4'h9 : 4'h0);
            chk($sformatf("rst-rel out t%0d", t), b0.out, (t == 7) ? 4'h9 : 4'h0);
        end
        b0.in = 4'h0;
        idle(20);

        b0.in = 4'h8;
        for (int t = 1; t <= 30; t++) begin
            step();
            chk($sformatf("both out t%0d", t), b1.out, (t == 7 || t == 17) ? 4'h8 : 4'h0);
            chk($sformatf("rise out t%0d", t), b0.out, (t == 7) ? 4'h8 : 4'h0);
            if (t == 10) b0.in = 4'h0;
        end

        begin
            logic [3:0] acc_o;
            logic [3:0] acc_l;
            acc_o = 4'h0;
            acc_l = 4'h0;
            repeat (20) begin
                step();
                acc_o |= b2.out;
                acc_l |= b2.level;
            end
            chk("actlow idle out", acc_o, 4'h0);
            chk("actlow idle level", acc_l, 4'h0);
        end
        b2.in = 4'hD;
        for (int t = 1; t <= 10; t++) begin
            step();
            chk($sformatf("actlow lvl t%0d", t), b2.level, (t >= 6) ? 4'h2 : 4'h0);
            chk($sformatf("actlow out t%0d", t), b2.out, (t == 7) ? 4'h2 : 4'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
